extend_unit: RTL and testbench



---
 rtl/extend_pkg.sv | 21 ++
 rtl/extend_core.sv | 34 +++
 rtl/extend_unit.sv | 58 +++++
 tb/tb_extend_unit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/extend_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : extend_pkg
//  Purpose  : Shared extension-mode encodings and width constants for the
//             immediate-extension unit.
//  Revision : 1.0  initial release
// ============================================================================
package extend_pkg;

    localparam int IMM_IN_W  = 16;
    localparam int IMM_OUT_W = 32;

    typedef enum logic [1:0] {
        EXT_SIGN   = 2'b00,
        EXT_ZERO   = 2'b01,
        EXT_LUI    = 2'b10,
        EXT_BRANCH = 2'b11
    } ext_mode_e;

endpackage : extend_pkg
`default_nettype wire

// File: rtl/extend_core.sv
`default_nettype none
// ============================================================================
//  Module   : extend_core
//  Purpose  : Combinational mode mux turning a 16-bit immediate into a
//             32-bit operand (sign, zero, LUI, branch word offset).
//  Revision : 1.0  initial release
// ============================================================================
module extend_core
    import extend_pkg::*;
(
    input  logic [1:0]           extMode,
    input  logic [IMM_IN_W-1:0]  offsetIn,
    output logic [IMM_OUT_W-1:0] immediateComb
);

    localparam int c_EXT_W = IMM_OUT_W - IMM_IN_W;

    logic w_sign;
    assign w_sign = offsetIn[IMM_IN_W-1];

    always_comb begin
        immediateComb = {{c_EXT_W{w_sign}}, offsetIn};
        case (ext_mode_e'(extMode))
            EXT_SIGN:   immediateComb = {{c_EXT_W{w_sign}}, offsetIn};
            EXT_ZERO:   immediateComb = {{c_EXT_W{1'b0}}, offsetIn};
            EXT_LUI:    immediateComb = {offsetIn, {c_EXT_W{1'b0}}};
            // Word offset: the two sign bits that would overflow are dropped.
            EXT_BRANCH: immediateComb = {{(c_EXT_W-2){w_sign}}, offsetIn, 2'b00};
            default:    immediateComb = {{c_EXT_W{w_sign}}, offsetIn};
        endcase
    end

endmodule : extend_core
`default_nettype wire

// File: rtl/extend_unit.sv
`default_nettype none
// ============================================================================
//  Module   : extend_unit
//  Purpose  : Immediate-extension unit: combinational result plus a
//             registered, valid-qualified copy for pipelined datapaths.
//  Revision : 1.0  initial release
// ============================================================================
module extend_unit
    import extend_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inValid,
    input  logic [1:0]           extMode,
    input  logic [IMM_IN_W-1:0]  offsetIn,
    output logic [IMM_OUT_W-1:0] immediateComb,
    output logic [IMM_OUT_W-1:0] immediate,
    output logic                 outValid
);

    logic [IMM_OUT_W-1:0] w_imm_comb;
    logic [IMM_OUT_W-1:0] w_imm_d;
    logic [IMM_OUT_W-1:0] r_imm_q;
    logic                 w_out_valid_d;
    logic                 r_out_valid_q;

    extend_core u_core (
        .extMode       (extMode),
        .offsetIn      (offsetIn),
        .immediateComb (w_imm_comb)
    );

    // Result holds between captures; the valid flag is a one-cycle pulse.
    always_comb begin
        w_imm_d       = r_imm_q;
        w_out_valid_d = 1'b0;
        if (inValid) begin
            w_imm_d       = w_imm_comb;
            w_out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_imm_q       <= '0;
            r_out_valid_q <= 1'b0;
        end else begin
            r_imm_q       <= w_imm_d;
            r_out_valid_q <= w_out_valid_d;
        end
    end

    assign immediateComb = w_imm_comb;
    assign immediate     = r_imm_q;
    assign outValid      = r_out_valid_q;

endmodule : extend_unit
`default_nettype wire

// File: tb/tb_extend_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_extend_unit
//  Purpose  : Self-checking bench for extend_unit against an arithmetic
//             reference model, with directed and random stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_extend_unit;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic [1:0]  extMode;
    logic [15:0] offsetIn;
    logic [31:0] immediateComb;
    logic [31:0] immediate;
    logic        outValid;

    int          errors;
    int          checks;
    logic [31:0] exp_imm;
    logic        exp_valid;

    extend_unit dut (
        .clk           (clk),
        .rst           (rst),
        .inValid       (inValid),
        .extMode       (extMode),
        .offsetIn      (offsetIn),
        .immediateComb (immediateComb),
        .immediate     (immediate),
        .outValid      (outValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference extension computed with integer arithmetic.
    function automatic logic [31:0] ref_ext(input logic [1:0] m, input logic [15:0] o);
        logic signed [31:0] s;
        logic        [31:0] u;
        s = 32'($signed(o));
        u = 32'(o);
        case (m)
            2'd0:    return s;
            2'd1:    return u;
            2'd2:    return u * 32'd65536;
            default: return s * 32'sd4;
        endcase
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check the combinational path, clock, check the register.
    task automatic step(input logic r, input logic v, input logic [1:0] m, input logic [15:0] o);
        rst      = r;
        inValid  = v;
        extMode  = m;
        offsetIn = o;
        #1;
        check32("comb", immediateComb, ref_ext(m, o));
        @(posedge clk);
        if (r) begin
            exp_imm   = 32'h0;
            exp_valid = 1'b0;
        end else if (v) begin
            exp_imm   = ref_ext(m, o);
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        #1;
        check32("imm", immediate, exp_imm);
        check1("valid", outValid, exp_valid);
    endtask

    task automatic directed(input logic [1:0] m, input logic [15:0] o, input logic [31:0] lit);
        rst      = 1'b0;
        inValid  = 1'b1;
        extMode  = m;
        offsetIn = o;
        #1;
        check32("comb_lit", immediateComb, lit);
        step(1'b0, 1'b1, m, o);
        check32("imm_lit", immediate, lit);
    endtask

    logic [15:0] sign_in  [9] = '{16'hAABB, 16'h1515, 16'h2044, 16'hAFFC, 16'h0002,
                                  16'h2323, 16'h9875, 16'hABCD, 16'hEF01};
    logic [31:0] sign_out [9] = '{32'hFFFFAABB, 32'h00001515, 32'h00002044, 32'hFFFFAFFC,
                                  32'h00000002, 32'h00002323, 32'hFFFF9875, 32'hFFFFABCD,
                                  32'hFFFFEF01};

    initial begin
        errors    = 0;
        checks    = 0;
        exp_imm   = 32'h0;
        exp_valid = 1'b0;
        rst       = 1'b1;
        inValid   = 1'b0;
        extMode   = 2'b00;
        offsetIn  = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check32("reset_imm", immediate, 32'h0);
        check1("reset_valid", outValid, 1'b0);

        for (int i = 0; i < 9; i++) directed(2'b00, sign_in[i], sign_out[i]);

        directed(2'b01, 16'hAFFC, 32'h0000AFFC);
        directed(2'b10, 16'h2044, 32'h20440000);
        directed(2'b10, 16'h8000, 32'h80000000);
        directed(2'b01, 16'h8000, 32'h00008000);

        directed(2'b11, 16'h0002, 32'h00000008);
        directed(2'b11, 16'h9875, 32'hFFFE61D4);
        directed(2'b11, 16'h7FFF, 32'h0001FFFC);
        directed(2'b11, 16'hFFFF, 32'hFFFFFFFC);

        directed(2'b00, 16'hABCD, 32'hFFFFABCD);
        step(1'b0, 1'b0, 2'b01, 16'h1234);
        step(1'b0, 1'b0, 2'b10, 16'h5678);
        step(1'b0, 1'b0, 2'b11, 16'h9ABC);
        check32("hold_imm", immediate, 32'hFFFFABCD);
        check1("hold_valid", outValid, 1'b0);

        step(1'b1, 1'b1, 2'b00, 16'hEF01);
        check32("rst_imm", immediate, 32'h0);
        check1("rst_valid", outValid, 1'b0);
        directed(2'b00, 16'h1515, 32'h00001515);
        check1("post_rst_valid", outValid, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_extend_unit
`default_nettype wire
